// File: rtl/acc_seq_ctrl_if.sv
// Control/status bundle between the accumulator sequencer
// and the decoder, ALU and accumulator pair around it.
interface acc_seq_ctrl_if;
  logic       start;
  logic       op;
  logic       operand_zero;
  logic       acc_low_lsb;
  logic       acc_high_msb;
  logic       alu_carry;
  logic       busy;
  logic       done;
  logic       div_err;
  logic       alu_sub;
  logic       acc_in_select;
  logic [1:0] acc_high_select;
  logic [1:0] acc_low_select;
  logic       fill_value;
  logic       acc_high_reset_p;
  logic       acc_rd_en;

  modport master (
    output start,
    output op,
    output operand_zero,
    output acc_low_lsb,
    output acc_high_msb,
    output alu_carry,
    input  busy,
    input  done,
    input  div_err,
    input  alu_sub,
    input  acc_in_select,
    input  acc_high_select,
    input  acc_low_select,
    input  fill_value,
    input  acc_high_reset_p,
    input  acc_rd_en
  );

  modport slave (
    input  start,
    input  op,
    input  operand_zero,
    input  acc_low_lsb,
    input  acc_high_msb,
    input  alu_carry,
    output busy,
    output done,
    output div_err,
    output alu_sub,
    output acc_in_select,
    output acc_high_select,
    output acc_low_select,
    output fill_value,
    output acc_high_reset_p,
    output acc_rd_en
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Accumulator sequencer: shift-add multiply and restoring
// divide by steering the accumulator pair select codes.
module acc_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  acc_seq_ctrl_if.slave ctl
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD_H  = 4'd1;
  localparam logic [3:0] XFER    = 4'd2;
  localparam logic [3:0] CLR_H   = 4'd3;
  localparam logic [3:0] M_ADD   = 4'd4;
  localparam logic [3:0] M_SHIFT = 4'd5;
  localparam logic [3:0] D_SHIFT = 4'd6;
  localparam logic [3:0] D_SUB   = 4'd7;
  localparam logic [3:0] D_FIX   = 4'd8;
  localparam logic [3:0] DONE    = 4'd9;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             c_reg;
  logic             ext;
  logic             q_reg;
  logic             op_reg;
  logic             err_reg;

  logic             q;
  logic             last;

  logic             busy;
  logic             done;
  logic             div_err;
  logic             alu_sub;
  logic             in_sel;
  logic [1:0]       hsel;
  logic [1:0]       lsel;
  logic             fill;
  logic             hrst;
  logic             rd_en;

  // Restore is skipped when the shifted-out bit already
  // makes the partial remainder exceed the divisor.
  assign q    = ext | ~ctl.alu_carry;
  assign last = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      c_reg   <= 1'b0;
      ext     <= 1'b0;
      q_reg   <= 1'b0;
      op_reg  <= 1'b0;
      err_reg <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl.start) begin
            op_reg <= ctl.op;
            if (ctl.op && ctl.operand_zero) begin
              err_reg <= 1'b1;
              state   <= DONE;
            end else begin
              err_reg <= 1'b0;
              state   <= LOAD_H;
            end
          end
        end
        LOAD_H: state <= XFER;
        XFER:   state <= CLR_H;
        CLR_H: begin
          cnt   <= '0;
          c_reg <= 1'b0;
          q_reg <= 1'b0;
          state <= op_reg ? D_SHIFT : M_ADD;
        end
        M_ADD: begin
          c_reg <= ctl.acc_low_lsb & ctl.alu_carry;
          state <= M_SHIFT;
        end
        M_SHIFT: begin
          cnt   <= cnt + CNT_W'(1);
          state <= last ? DONE : M_ADD;
        end
        D_SHIFT: begin
          ext   <= ctl.acc_high_msb;
          state <= D_SUB;
        end
        D_SUB: begin
          q_reg <= q;
          cnt   <= cnt + CNT_W'(1);
          state <= last ? D_FIX : D_SHIFT;
        end
        D_FIX: state <= DONE;
        DONE: begin
          err_reg <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    div_err = 1'b0;
    alu_sub = 1'b0;
    in_sel  = 1'b0;
    hsel    = SEL_IDLE;
    lsel    = SEL_IDLE;
    fill    = 1'b0;
    hrst    = 1'b0;
    rd_en   = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD_H: begin
        busy   = 1'b1;
        in_sel = 1'b1;
        hsel   = SEL_LOAD;
      end
      XFER: begin
        busy = 1'b1;
        lsel = SEL_LOAD;
      end
      CLR_H: begin
        busy = 1'b1;
        hrst = 1'b1;
      end
      M_ADD: begin
        busy = 1'b1;
        if (ctl.acc_low_lsb) hsel = SEL_LOAD;
      end
      M_SHIFT: begin
        busy = 1'b1;
        hsel = SEL_SHR;
        lsel = SEL_SHR;
        fill = c_reg;
      end
      D_SHIFT: begin
        busy = 1'b1;
        hsel = SEL_SHL;
        lsel = SEL_SHL;
        fill = q_reg;
      end
      D_SUB: begin
        busy    = 1'b1;
        alu_sub = 1'b1;
        if (q) hsel = SEL_LOAD;
      end
      D_FIX: begin
        busy = 1'b1;
        lsel = SEL_SHL;
        fill = q_reg;
      end
      DONE: begin
        done    = 1'b1;
        rd_en   = 1'b1;
        div_err = err_reg;
      end
      default: ;
    endcase
  end

  assign ctl.busy             = busy;
  assign ctl.done             = done;
  assign ctl.div_err          = div_err;
  assign ctl.alu_sub          = alu_sub;
  assign ctl.acc_in_select    = in_sel;
  assign ctl.acc_high_select  = hsel;
  assign ctl.acc_low_select   = lsel;
  assign ctl.fill_value       = fill;
  assign ctl.acc_high_reset_p = hrst;
  assign ctl.acc_rd_en        = rd_en;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: accumulator pair and ALU model
// around the sequencer, with a result scoreboard.
module tb_acc_seq_ctrl;

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    logic       err;
    int         lat;
  } exp_t;

  logic clk;
  logic reset_n;

  acc_seq_ctrl_if ctl();

  acc_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctl     (ctl)
  );

  logic [3:0] hi;
  logic [3:0] lo;
  logic [3:0] bus_val;
  logic [3:0] b_val;
  logic [4:0] alu_res;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (ctl.alu_sub) alu_res = {1'b0, hi} - {1'b0, b_val};
    else             alu_res = {1'b0, hi} + {1'b0, b_val};
    ctl.alu_carry    = alu_res[4];
    ctl.acc_low_lsb  = lo[0];
    ctl.acc_high_msb = hi[3];
    ctl.operand_zero = (b_val == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (ctl.acc_high_reset_p) hi <= 4'h0;
    else begin
      case (ctl.acc_high_select)
        2'b01:   hi <= {ctl.fill_value, hi[3:1]};
        2'b10:   hi <= {hi[2:0], lo[3]};
        2'b11:   hi <= ctl.acc_in_select ? bus_val : alu_res[3:0];
        default: ;
      endcase
    end
    case (ctl.acc_low_select)
      2'b01:   lo <= {hi[0], lo[3:1]};
      2'b10:   lo <= {lo[2:0], ctl.fill_value};
      2'b11:   lo <= hi;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {ctl.busy, ctl.done, ctl.div_err, ctl.alu_sub,
            ctl.acc_in_select, ctl.acc_high_select,
            ctl.acc_low_select, ctl.fill_value,
            ctl.acc_high_reset_p, ctl.acc_rd_en};
  endfunction

  task automatic run_op(input logic op_i,
                        input logic [3:0] a,
                        input logic [3:0] b,
                        input int pulse_at);
    exp_t       e;
    exp_t       g;
    logic [7:0] prod;
    int         busy_n;
    int         done_n;
    e.err = 1'b0;
    if (!op_i) begin
      prod  = 8'(a) * 8'(b);
      e.hi  = prod[7:4];
      e.lo  = prod[3:0];
      e.lat = 12;
    end else if (b == 4'h0) begin
      e.hi  = hi;
      e.lo  = lo;
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      e.hi  = a % b;
      e.lo  = a / b;
      e.lat = 13;
    end
    sb.push_back(e);
    bus_val   = a;
    b_val     = b;
    ctl.op    = op_i;
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int n = 1; n <= 20; n++) begin
      if (ctl.busy) busy_n++;
      if (ctl.done) begin
        done_n++;
        if (sb.size() > 0) begin
          g = sb.pop_front();
          chk("done_cycle", 16'(n), 16'(g.lat));
          chk("acc_high", 16'(hi), 16'(g.hi));
          chk("acc_low", 16'(lo), 16'(g.lo));
          chk("div_err", 16'(ctl.div_err), 16'(g.err));
          chk("rd_en", 16'(ctl.acc_rd_en), 16'd1);
        end
      end
      ctl.start = (n == pulse_at);
      tick();
    end
    ctl.start = 1'b0;
    chk("done_count", 16'(done_n), 16'd1);
    chk("busy_cycles", 16'(busy_n), 16'(e.lat > 1 ? e.lat - 1 : 0));
    chk("sb_empty", 16'(sb.size()), 16'd0);
    while (sb.size() > 0) void'(sb.pop_front());
  endtask

  initial begin
    int done_n;
    vectors     = 0;
    miscompares = 0;
    reset_n   = 1'b0;
    ctl.start = 1'b0;
    ctl.op    = 1'b0;
    bus_val   = 4'h0;
    b_val     = 4'h1;
    tick();
    tick();
    chk("reset_outs", 16'(outs()), 16'h0);
    reset_n = 1'b1;
    tick();
    chk("idle_outs", 16'(outs()), 16'h0);

    run_op(1'b0, 4'hD, 4'hB, 0);
    run_op(1'b0, 4'hF, 4'hF, 0);
    run_op(1'b0, 4'h0, 4'h9, 0);
    run_op(1'b1, 4'hD, 4'h3, 0);
    run_op(1'b1, 4'hF, 4'h1, 0);
    run_op(1'b1, 4'h2, 4'h7, 0);
    run_op(1'b1, 4'h5, 4'h0, 0);
    run_op(1'b0, 4'hD, 4'hB, 5);

    // Divide aborted by reset in its sixth cycle
    bus_val   = 4'hD;
    b_val     = 4'h3;
    ctl.op    = 1'b1;
    ctl.start = 1'b1;
    tick();
    ctl.start = 1'b0;
    for (int n = 1; n < 6; n++) tick();
    chk("pre_abort_busy", 16'(ctl.busy), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_outs", 16'(outs()), 16'h0);
    tick();
    reset_n = 1'b1;
    done_n = 0;
    for (int n = 0; n < 12; n++) begin
      if (ctl.done || ctl.busy) done_n++;
      tick();
    end
    chk("abort_quiet", 16'(done_n), 16'd0);

    run_op(1'b1, 4'hD, 4'h3, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Sequencer that drives the accumulator's control inputs to run a 4x4 unsigned shift-add multiply or a 4/4 restoring divide.
- Sits between the instruction decoder and the accumulator pair (high/low halves).
- Generates the half-select codes, fill bit, input mux select and high-half clear each cycle.
- Reads back the accumulator bits and ALU flags it needs to decide each step.

Parameters:
- WIDTH, 4, accumulator half width; also the iteration count.
- CNT_W, 3, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide; sampled with start
- operand_zero  input  1  ALU B operand (multiplier/divisor) is zero; sampled with start
- acc_low_lsb  input  1  accumulator low bit 0
- acc_high_msb  input  1  accumulator high bit 3
- alu_carry  input  1  ALU carry-out (ADD) / borrow-out (SUB), 1 = borrow
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_err  output  1  divide-by-zero flag, valid with done
- alu_sub  output  1  0 = ALU add, 1 = ALU subtract
- acc_in_select  output  1  1 = bus into high half, 0 = ALU into high half
- acc_high_select  output  2  00 idle, 01 shift right, 10 shift left, 11 load
- acc_low_select  output  2  same encoding as high
- fill_value  output  1  bit inserted on shift
- acc_high_reset_p  output  1  clears high half (active-high)
- acc_rd_en  output  1  drives accumulator onto bus

Behaviour:
- Reset values (async, reset_n low):
  - state = IDLE.
  - All outputs 0, selects 00.
  - Counter, carry latch c_reg, extension bit ext and quotient bit q_reg all 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- Operands:
  - Dividend/multiplier comes from the bus during LOAD_H.
  - B is presented by the external ALU operand register and must stay stable while busy.
- States: IDLE, LOAD_H, XFER, CLR_H, M_ADD, M_SHIFT, D_SHIFT, D_SUB, D_FIX, DONE.
- Transitions and per-state outputs:
  - IDLE: on start:
    - if op=1 and operand_zero=1 -> DONE with div_err=1 and no accumulator writes;
    - otherwise -> LOAD_H.
  - IDLE: start is ignored in every other state.
  - LOAD_H: acc_in_select=1, high=11 -> XFER.
  - XFER: low=11 (high copied to low), high=00 -> CLR_H.
  - CLR_H: acc_high_reset_p=1 for 1 cycle; counter=0 -> M_ADD if op=0, else D_SHIFT.
  - M_ADD:
    - if acc_low_lsb=1: alu_sub=0, acc_in_select=0, high=11, c_reg<=alu_carry;
    - else high=00, c_reg<=0.
    - -> M_SHIFT.
  - M_SHIFT: high=01, low=01, fill_value=c_reg; counter+1.
    - -> DONE if counter reaches WIDTH-1 before increment, else M_ADD.
  - D_SHIFT: high=10, low=10, fill_value=q_reg; ext<=acc_high_msb -> D_SUB.
  - D_SUB: alu_sub=1; q = ext | ~alu_carry.
    - if q: acc_in_select=0, high=11;
    - q_reg<=q; counter+1.
    - -> D_FIX after WIDTH iterations, else D_SHIFT.
  - D_FIX: low=10, high=00, fill_value=q_reg -> DONE.
  - DONE: done=1, acc_rd_en=1, div_err held for this cycle -> IDLE.
- The first D_SHIFT inserts fill 0 (q_reg cleared in CLR_H). That bit is shifted out by D_FIX.
- Results:
  - Multiply: product = {high, low}.
  - Divide: quotient in low, remainder in high.
- busy=1 in every state except IDLE and DONE.
- Latency from the start cycle:
  - multiply: done in cycle 12 (11 busy cycles);
  - divide: done in cycle 13;
  - divide-by-zero: done in cycle 1.
- All unspecified outputs are 0 in each state.

Test Plan:
- Multiply 13 x 11 (bus=0xD, B=0xB) -> done at cycle 12, high=0x8, low=0xF (143); busy high for exactly 11 cycles.
- Multiply 15 x 15 -> high=0xE, low=0x1; multiply 0 x 9 -> high=0x0, low=0x0; no div_err.
- Divide 13 / 3 -> done at cycle 13, low=0x4, high=0x1. Divide 15 / 1 -> low=0xF, high=0x0. Divide 2 / 7 -> low=0x0, high=0x2.
- Divide with operand_zero=1 -> done and div_err at cycle 1, accumulator unchanged, busy never asserted.
- start pulsed during busy (cycle 5 of a multiply) -> ignored; single done, result unchanged.
- reset_n low at cycle 6 of a divide -> all outputs 0 immediately, no done. Next start runs normally to the correct result.
